// File: rtl/host_seq_if.sv
// Bundle of controller-side and processor-side signals of the host sequencer.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface host_seq_if #(
  parameter int CW = 16
);
  logic          start;
  logic [1:0]    prog_sel;
  logic          dut_init;
  logic          dut_req;
  logic          dut_ack;
  logic [1:0]    run_prog;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic [7:0]    runs;

  modport slave (
    input  start, prog_sel, dut_ack,
    output dut_init, dut_req, run_prog, busy, done, timeout, cycles, runs
  );

  modport master (
    output start, prog_sel, dut_ack,
    input  dut_init, dut_req, run_prog, busy, done, timeout, cycles, runs
  );
endinterface

// File: rtl/host_seq.sv
// Host sequencer: resets a processor, requests a program run, waits for its
// done flag (or a cycle timeout) and reports the outcome and run count.
module host_seq #(
  parameter int          INIT_CYC = 4,
  parameter int          CW       = 16,
  parameter int unsigned TIMEOUT  = 32'h0000_FFFF
) (
  input logic       clk,
  input logic       init_n,
  host_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [3:0]    INIT_LD = 4'(INIT_CYC - 1);
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [3:0]    init_cnt_q, init_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    run_prog_q, run_prog_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [7:0]    runs_q, runs_d;
  logic          dut_init_q, dut_init_d;
  logic          dut_req_q, dut_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and datapath update; outputs are decoded from the next state
  // so every output flop reflects the state it is entering.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;
    run_prog_d = run_prog_q;
    timeout_d  = timeout_q;
    cycles_d   = cycles_q;
    runs_d     = runs_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_RST;
          run_prog_d = bus.prog_sel;
          timeout_d  = 1'b0;
          init_cnt_d = INIT_LD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RST: begin
        if (init_cnt_q == 4'd0) begin
          state_d = S_REQ;
        end else begin
          init_cnt_d = init_cnt_q - 4'd1;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done flag in the same cycle as the limit still counts as success.
        if (bus.dut_ack) begin
          state_d   = S_FIN;
          cycles_d  = cnt_q;
          timeout_d = 1'b0;
          runs_d    = runs_q + 8'd1;
        end else if (cnt_q == TMO) begin
          state_d   = S_FIN;
          cycles_d  = TMO;
          timeout_d = 1'b1;
          runs_d    = runs_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    dut_init_d = (state_d == S_RST);
    dut_req_d  = (state_d == S_REQ);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q    <= S_IDLE;
      init_cnt_q <= 4'd0;
      cnt_q      <= '0;
      run_prog_q <= 2'd0;
      timeout_q  <= 1'b0;
      cycles_q   <= '0;
      runs_q     <= 8'd0;
      dut_init_q <= 1'b0;
      dut_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cnt_q      <= cnt_d;
      run_prog_q <= run_prog_d;
      timeout_q  <= timeout_d;
      cycles_q   <= cycles_d;
      runs_q     <= runs_d;
      dut_init_q <= dut_init_d;
      dut_req_q  <= dut_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.dut_init = dut_init_q;
  assign bus.dut_req  = dut_req_q;
  assign bus.run_prog = run_prog_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
  assign bus.cycles   = cycles_q;
  assign bus.runs     = runs_q;

endmodule

// File: tb/tb_host_seq.sv
// Randomized scoreboard bench for host_seq: each run's expected outcome is
// derived from the ack delay and queued; a negedge monitor checks it at done.
module tb_host_seq;

  localparam int INIT_CYC = 4;
  localparam int CW       = 16;
  localparam int TO       = 20;

  logic clk;
  logic init_n;

  host_seq_if #(.CW(CW)) bus ();

  host_seq #(.INIT_CYC(INIT_CYC), .CW(CW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0]    prog;
    logic [CW-1:0] cyc;
    logic          tmo;
    logic [7:0]    runs;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] runs_m = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each done pulse.
  initial begin : monitor
    int   n_init = 0;
    int   n_req  = 0;
    logic prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!init_n) begin
        n_init = 0;
        n_req  = 0;
        prev_done = 1'b0;
      end else begin
        if (bus.dut_init && bus.dut_req) chk("init_req_overlap", 32'd1, 32'd0);
        if (bus.dut_init) n_init++;
        if (bus.dut_req)  n_req++;
        if (bus.done) begin
          if (prev_done) chk("done_width", 32'd2, 32'd1);
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("run_prog", 32'(bus.run_prog), 32'(e.prog));
            chk("cycles",   32'(bus.cycles),   32'(e.cyc));
            chk("timeout",  32'(bus.timeout),  32'(e.tmo));
            chk("runs",     32'(bus.runs),     32'(e.runs));
            chk("init_len", 32'(n_init),       32'(INIT_CYC));
            chk("req_len",  32'(n_req),        32'd1);
          end
          n_init = 0;
          n_req  = 0;
        end
        prev_done = bus.done;
      end
    end
  end

  // Reference outcome: ack seen after d ack-low wait cycles, or the limit.
  task automatic push_exp(input logic [1:0] prog, input int d);
    exp_t e;
    runs_m = runs_m + 8'd1;
    e.prog = prog;
    e.cyc  = (d <= TO) ? CW'(d) : CW'(TO);
    e.tmo  = (d > TO);
    e.runs = runs_m;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [1:0] prog, input int d, input bit push);
    int n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) chk("idle_wait", 32'd0, 32'd1);
    if (push) push_exp(prog, d);
    bus.prog_sel = prog;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.prog_sel = 2'($urandom_range(0, 3));
    // A stale ack from the previous run is still high here and must be ignored.
    @(posedge clk); #1;
    bus.dut_ack = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      if (bus.dut_req) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!ok) chk("req_wait", 32'd0, 32'd1);
  endtask

  task automatic finish_run(input int d, input bit stale, input bit poke);
    bit ok;
    int k = 0;
    int n = 0;
    wait_req(ok);
    if (!ok) return;
    @(posedge clk); #1;
    if (poke) begin
      bus.start    = 1'b1;
      bus.prog_sel = 2'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      k = 1;
    end
    if (d <= TO) begin
      while (k < d) begin
        @(posedge clk); #1;
        k++;
      end
      bus.dut_ack = 1'b1;
    end
    while (!bus.done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.done) chk("done_wait", 32'd0, 32'd1);
    if (!stale) bus.dut_ack = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dut_init"}, 32'(bus.dut_init), 32'd0);
    chk({tag, "_dut_req"},  32'(bus.dut_req),  32'd0);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_done"},     32'(bus.done),     32'd0);
    chk({tag, "_timeout"},  32'(bus.timeout),  32'd0);
    chk({tag, "_cycles"},   32'(bus.cycles),   32'd0);
    chk({tag, "_runs"},     32'(bus.runs),     32'd0);
    chk({tag, "_run_prog"}, 32'(bus.run_prog), 32'd0);
  endtask

  initial begin : driver
    int   d;
    bit   ok;
    logic [1:0] p;
    init_n       = 1'b0;
    bus.start    = 1'b1;
    bus.prog_sel = 2'd1;
    bus.dut_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");

    // Start held through reset is taken in the first released cycle.
    push_exp(2'd1, 10);
    init_n = 1'b1;
    @(posedge clk); #1;
    chk("first_start_busy", 32'(bus.busy),     32'd1);
    chk("first_start_init", 32'(bus.dut_init), 32'd1);
    bus.start = 1'b0;
    finish_run(10, 1'b1, 1'b0);

    launch(2'd3, TO + 1, 1'b1);  finish_run(TO + 1, 1'b0, 1'b0);
    launch(2'd2, TO, 1'b1);      finish_run(TO, 1'b0, 1'b0);
    launch(2'd0, 0, 1'b1);       finish_run(0, 1'b1, 1'b0);
    launch(2'd1, 5, 1'b1);       finish_run(5, 1'b0, 1'b1);

    // Abort in the middle of a wait; no done may follow.
    launch(2'd3, 30, 1'b0);
    wait_req(ok);
    repeat (6) begin
      @(posedge clk); #1;
    end
    init_n = 1'b0;
    @(posedge clk); #1;
    init_n = 1'b1;
    runs_m = 8'd0;
    chk_reset_outputs("abort");
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_idle", 32'(bus.busy), 32'd0);

    // 256 random runs: the run counter must wrap back to zero on the last.
    for (int i = 0; i < 256; i++) begin
      d = $urandom_range(0, TO + 4);
      p = 2'($urandom_range(0, 3));
      launch(p, d, 1'b1);
      finish_run(d, 1'($urandom_range(0, 1)), (d >= 2) && ($urandom_range(0, 3) == 0));
    end
    bus.dut_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("runs_wrapped", 32'(bus.runs), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_seq.md
HOST_SEQ -- requirements
Module: host_seq

Interface
REQ-001 Parameter INIT_CYC, default 4: number of cycles dut_init is held high per run (legal 1..15).
REQ-002 Parameter CW, default 16: width of the cycle counter and the cycles output.
REQ-003 Parameter TIMEOUT, default 16'hFFFF: maximum WAIT cycles before a run is abandoned (legal 1..2^CW-1).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 init_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  run request from the external controller; sampled only in IDLE.
REQ-007 prog_sel  in  2  program number, captured on the accepted start.
REQ-008 dut_init  out  1  active-high reset to the processor.
REQ-009 dut_req  out  1  start request to the processor.
REQ-010 dut_ack  in  1  processor done flag; level, stays high until the processor is reset.
REQ-011 run_prog  out  2  prog_sel latched at the accepted start.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at the end of each run.
REQ-014 timeout  out  1  high if the last run ended by timeout; valid from done until the next accepted start.
REQ-015 cycles  out  CW  WAIT-cycle count of the last run.
REQ-016 runs  out  8  completed-run counter, wraps 255->0.

Function
REQ-017 FSM states: IDLE, RST, REQ, WAIT, FIN; all outputs registered.
REQ-018 IDLE: start=1 -> RST; capture prog_sel into run_prog; clear timeout; load init counter with INIT_CYC-1.
REQ-019 RST: dut_init=1; init counter decrements each cycle; at 0 -> REQ.
REQ-020 REQ: dut_req=1 for exactly one cycle; cycle counter cleared to 0; -> WAIT.
REQ-021 WAIT: dut_ack=1 -> FIN with cycles<=counter, timeout<=0.
REQ-022 WAIT: dut_ack=0 and counter==TIMEOUT -> FIN with cycles<=TIMEOUT, timeout<=1.
REQ-023 WAIT: any other case -> counter increments by 1 and FSM stays in WAIT; counter never exceeds TIMEOUT.
REQ-024 FIN: done=1 for one cycle; runs increments modulo 256; -> IDLE.
REQ-025 Latency: start sampled at edge 0 -> dut_init high for edges 1..INIT_CYC, dut_req high for edge INIT_CYC+1, first WAIT cycle at INIT_CYC+2.
REQ-026 dut_ack is ignored in IDLE, RST, REQ and FIN, including a stale high left over from the previous run.
REQ-027 Simultaneous dut_ack=1 and counter==TIMEOUT in WAIT: ack wins; timeout=0, cycles=TIMEOUT.
REQ-028 start while busy=1 is ignored and is not queued; start held high through FIN begins a new run from the IDLE cycle that follows.
REQ-029 dut_init and dut_req are never high in the same cycle.
REQ-030 cycles, timeout, run_prog and runs hold their values between runs.

Reset
REQ-031 init_n=0 at a clock edge -> IDLE; dut_init=0, dut_req=0, busy=0, done=0, timeout=0, cycles=0, runs=0, run_prog=0; all counters cleared.
REQ-032 Reset takes priority over start and over any in-progress run; no done pulse is emitted for an aborted run.
REQ-033 First run after reset: start is accepted in the first cycle with init_n=1.

Verification
REQ-034 INIT_CYC=4, start pulse, ack rises 10 cycles after dut_req -> dut_init high 4 cycles, dut_req 1 cycle, done pulse, cycles=10, timeout=0, runs=1.
REQ-035 TIMEOUT=20, ack held low -> done 21 cycles after dut_req, cycles=20, timeout=1.
REQ-036 Ack still high from the previous run at the next start -> ignored through RST/REQ; tie ack low in RST -> run completes normally with the correct cycles value.
REQ-037 init_n=0 during WAIT at cycle 5 -> IDLE next edge, all outputs reset, no done pulse.
REQ-038 start pulsed during WAIT, prog_sel=2 -> ignored, run_prog unchanged; 256 completed runs -> runs wraps to 0.
REQ-039 TIMEOUT=8, ack rises on the same cycle counter==8 -> timeout=0, cycles=8.
